// File: rtl/sprite_blitter_if.sv
// Bundle of command, sprite-ROM read and frame-buffer write signals for sprite_blitter.
// The slave modport is the blitter; master is whatever issues blits and hosts the memories.
interface sprite_blitter_if;
    logic        start;
    logic [15:0] src_base;
    logic [6:0]  spr_w;
    logic [6:0]  spr_h;
    logic [8:0]  dst_x;
    logic [7:0]  dst_y;
    logic        mirror;
    logic [15:0] src_addr;
    logic [11:0] src_data;
    logic [17:0] fb_addr;
    logic [11:0] fb_data;
    logic        fb_we;
    logic        busy;
    logic        done;

    modport slave (
        input  start, src_base, spr_w, spr_h, dst_x, dst_y, mirror, src_data,
        output src_addr, fb_addr, fb_data, fb_we, busy, done
    );

    modport master (
        output start, src_base, spr_w, spr_h, dst_x, dst_y, mirror, src_data,
        input  src_addr, fb_addr, fb_data, fb_we, busy, done
    );
endinterface

// File: rtl/sprite_blitter.sv
// Copies a sprite from ROM into the frame buffer at one pixel per clock, skipping key-colour
// pixels and clipping at the buffer edge. Horizontal mirroring is built only with BLIT_MIRROR_EN.
module sprite_blitter #(
    parameter int          VBUF_W    = 320,
    parameter int          VBUF_H    = 240,
    parameter logic [11:0] KEY_COLOR = 12'h0F0
) (
    input  logic clk,
    input  logic reset_n,
    sprite_blitter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state;
    logic [6:0]  w_q, h_q;
    logic [8:0]  dx_q;
    logic [7:0]  dy_q;
    logic [6:0]  col, row;
    logic [15:0] row_base;
    logic [15:0] src_addr_q;
    logic [17:0] fb_addr_q;
    logic        wr_valid, wr_clip;
    logic        busy_q, done_q;

    logic        last_col, last_row;
    logic [6:0]  next_col, next_scol, start_scol;
    logic [15:0] next_row_base;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;

`ifdef BLIT_MIRROR_EN
    logic        mir_q;
`else
    logic        unused_mirror;
    assign unused_mirror = bus.mirror;
`endif

    // row_base tracks src_base + row*spr_w so no multiplier sits on the read-address path.
    always_comb begin
        last_col      = (col == w_q - 7'd1);
        last_row      = (row == h_q - 7'd1);
        next_col      = last_col ? 7'd0 : col + 7'd1;
        next_row_base = last_col ? row_base + {9'd0, w_q} : row_base;
`ifdef BLIT_MIRROR_EN
        next_scol     = mir_q ? (w_q - 7'd1 - next_col) : next_col;
        start_scol    = bus.mirror ? (bus.spr_w - 7'd1) : 7'd0;
`else
        next_scol     = next_col;
        start_scol    = 7'd0;
`endif
        pix_x         = {1'b0, dx_q} + {3'd0, col};
        pix_y         = {1'b0, dy_q} + {2'd0, row};
    end

    // Each issued address carries its destination and clip flag one stage forward to meet the ROM data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            w_q        <= '0;
            h_q        <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            col        <= '0;
            row        <= '0;
            row_base   <= '0;
            src_addr_q <= '0;
            fb_addr_q  <= '0;
            wr_valid   <= 1'b0;
            wr_clip    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef BLIT_MIRROR_EN
            mir_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        w_q        <= bus.spr_w;
                        h_q        <= bus.spr_h;
                        dx_q       <= bus.dst_x;
                        dy_q       <= bus.dst_y;
`ifdef BLIT_MIRROR_EN
                        mir_q      <= bus.mirror;
`endif
                        col        <= '0;
                        row        <= '0;
                        row_base   <= bus.src_base;
                        src_addr_q <= bus.src_base + {9'd0, start_scol};
                        if (bus.spr_w == 7'd0 || bus.spr_h == 7'd0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    wr_valid  <= 1'b1;
                    wr_clip   <= (pix_x >= 10'(VBUF_W)) | (pix_y >= 9'(VBUF_H));
                    fb_addr_q <= 18'(pix_y) * 18'(VBUF_W) + 18'(pix_x);
                    if (last_col && last_row) begin
                        state <= DRAIN;
                    end else begin
                        col        <= next_col;
                        row_base   <= next_row_base;
                        src_addr_q <= next_row_base + {9'd0, next_scol};
                        if (last_col) begin
                            row <= row + 7'd1;
                        end
                    end
                end
                DRAIN: begin
                    wr_valid <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.src_addr = src_addr_q;
    assign bus.fb_addr  = fb_addr_q;
    assign bus.fb_data  = bus.src_data;
    assign bus.fb_we    = wr_valid & ~wr_clip & (bus.src_data != KEY_COLOR);
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed cases from the blit rules plus randomized blits
// compared against a per-pixel arithmetic model of addresses, clipping and transparency.
module tb_sprite_blitter;
    localparam logic [11:0] KEY = 12'h0F0;

    logic clk;
    logic reset_n;
    sprite_blitter_if bus ();

    sprite_blitter #(.VBUF_W(320), .VBUF_H(240), .KEY_COLOR(KEY)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [11:0] rom [0:65535];
    logic [11:0] rom_q;
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom[bus.src_addr];
    assign bus.src_data = rom_q;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [11:0] randPixel();
        logic [11:0] p;
        p = 12'($urandom);
        if (p == KEY) p = 12'h000;
        return p;
    endfunction

    // Runs one blit from the accept edge through DONE, checking every cycle, and returns in the following IDLE cycle.
    task automatic applyStimulus(input logic [15:0] base, input int w, input int h, input int x, input int y,
                                 input logic mir, input bit hold, output int writes);
        int total, exp_writes, idx, r, c, sc, px, py;
        logic eff_mir, exp_we;
        logic [31:0] sa;
        logic [11:0] pd;
`ifdef BLIT_MIRROR_EN
        eff_mir = mir;
`else
        eff_mir = 1'b0;
`endif
        total = w * h;
        writes = 0;
        exp_writes = 0;
        bus.start    = 1'b1;
        bus.src_base = base;
        bus.spr_w    = 7'(w);
        bus.spr_h    = 7'(h);
        bus.dst_x    = 9'(x);
        bus.dst_y    = 8'(y);
        bus.mirror   = mir;
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            bus.start    = 1'b0;
            bus.src_base = 16'($urandom);
            bus.spr_w    = 7'($urandom);
            bus.spr_h    = 7'($urandom);
            bus.dst_x    = 9'($urandom);
            bus.dst_y    = 8'($urandom);
            bus.mirror   = 1'($urandom);
        end
        if (total == 0) begin
            checkOutput("zero_done", {31'd0, bus.done}, 32'd1);
            checkOutput("zero_busy", {31'd0, bus.busy}, 32'd0);
            checkOutput("zero_we", {31'd0, bus.fb_we}, 32'd0);
            @(negedge clk);
            checkOutput("zero_done_clear", {31'd0, bus.done}, 32'd0);
            checkOutput("zero_we_after", {31'd0, bus.fb_we}, 32'd0);
            return;
        end
        for (int k = 1; k <= total + 2; k++) begin
            checkOutput("busy", {31'd0, bus.busy}, (k <= total + 1) ? 32'd1 : 32'd0);
            checkOutput("done", {31'd0, bus.done}, (k == total + 2) ? 32'd1 : 32'd0);
            if (k <= total) begin
                idx = k - 1;
                r = idx / w;
                c = idx % w;
                sc = eff_mir ? (w - 1 - c) : c;
                sa = 32'(int'(base) + r * w + sc) & 32'h0000FFFF;
                checkOutput("src_addr", {16'd0, bus.src_addr}, sa);
            end
            if (k >= 2 && k <= total + 1) begin
                idx = k - 2;
                r = idx / w;
                c = idx % w;
                sc = eff_mir ? (w - 1 - c) : c;
                sa = 32'(int'(base) + r * w + sc) & 32'h0000FFFF;
                pd = rom[sa[15:0]];
                px = x + c;
                py = y + r;
                exp_we = (px < 320) && (py < 240) && (pd != KEY);
                checkOutput("fb_we", {31'd0, bus.fb_we}, {31'd0, exp_we});
                if (exp_we) begin
                    exp_writes++;
                    checkOutput("fb_addr", {14'd0, bus.fb_addr}, 32'(py * 320 + px));
                    checkOutput("fb_data", {20'd0, bus.fb_data}, {20'd0, pd});
                end
            end else begin
                checkOutput("fb_we_idle", {31'd0, bus.fb_we}, 32'd0);
            end
            if (bus.fb_we) writes++;
            @(negedge clk);
        end
        checkOutput("write_count", 32'(writes), 32'(exp_writes));
    endtask

    initial begin
        int wr, n;
        bus.start = 1'b0;
        bus.src_base = '0;
        bus.spr_w = '0;
        bus.spr_h = '0;
        bus.dst_x = '0;
        bus.dst_y = '0;
        bus.mirror = 1'b0;
        for (int i = 0; i < 65536; i++) rom[i] = randPixel();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
        checkOutput("rst_we", {31'd0, bus.fb_we}, 32'd0);
        checkOutput("rst_src_addr", {16'd0, bus.src_addr}, 32'd0);
        checkOutput("rst_fb_addr", {14'd0, bus.fb_addr}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic 4x2 blit");
        applyStimulus(16'h0100, 4, 2, 10, 20, 1'b0, 1'b0, wr);
        checkOutput("basic_writes", 32'(wr), 32'd8);

        $display("[TB] transparency");
        rom[16'h0102] = KEY;
        applyStimulus(16'h0100, 4, 2, 10, 20, 1'b0, 1'b0, wr);
        checkOutput("key_writes", 32'(wr), 32'd7);
        rom[16'h0102] = 12'h123;

        $display("[TB] clipping 64x32 at (300,230)");
        applyStimulus(16'h2000, 64, 32, 300, 230, 1'b0, 1'b0, wr);
        checkOutput("clip_writes", 32'(wr), 32'd200);

        $display("[TB] mirror 4x1");
        applyStimulus(16'h0400, 4, 1, 0, 0, 1'b1, 1'b0, wr);
        applyStimulus(16'hFFFE, 4, 2, 100, 100, 1'b1, 1'b0, wr);

        $display("[TB] zero-size requests");
        applyStimulus(16'h0500, 0, 5, 1, 1, 1'b0, 1'b0, wr);
        applyStimulus(16'h0500, 5, 0, 1, 1, 1'b0, 1'b0, wr);

        $display("[TB] start held high");
        applyStimulus(16'h0200, 3, 2, 5, 5, 1'b0, 1'b1, wr);
        checkOutput("hold_idle_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        checkOutput("hold_restart_busy", {31'd0, bus.busy}, 32'd1);
        checkOutput("hold_restart_addr", {16'd0, bus.src_addr}, 32'h0200);
        bus.start = 1'b0;
        n = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (bus.done) begin
                n = i;
                break;
            end
        end
        checkOutput("hold_done_at", 32'(n), 32'd7);
        @(negedge clk);
        checkOutput("hold_no_third", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        checkOutput("hold_no_third2", {31'd0, bus.busy}, 32'd0);

        $display("[TB] reset mid-run");
        bus.start = 1'b1;
        bus.src_base = 16'h3000;
        bus.spr_w = 7'd8;
        bus.spr_h = 7'd8;
        bus.dst_x = 9'd50;
        bus.dst_y = 8'd50;
        bus.mirror = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_we", {31'd0, bus.fb_we}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_we", {31'd0, bus.fb_we}, 32'd0);
        checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("midrst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("postrst_busy", {31'd0, bus.busy}, 32'd0);
            checkOutput("postrst_done", {31'd0, bus.done}, 32'd0);
        end
        applyStimulus(16'h0100, 4, 2, 10, 20, 1'b0, 1'b0, wr);
        checkOutput("postrst_writes", 32'(wr), 32'd8);

        $display("[TB] randomized blits");
        for (int i = 0; i < 65536; i++) if ($urandom_range(7) == 0) rom[i] = KEY;
        for (int t = 0; t < 10; t++) begin
            applyStimulus((t % 3 == 0) ? 16'($urandom_range(65535, 65400)) : 16'($urandom),
                          $urandom_range(16, 1), $urandom_range(10, 1),
                          (t % 2 == 0) ? $urandom_range(330, 300) : $urandom_range(511, 0),
                          (t % 2 == 0) ? $urandom_range(245, 230) : $urandom_range(255, 0),
                          1'($urandom), 1'b0, wr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Pixel-copy engine that writes a rectangular sprite from a 12-bit sprite ROM into the 320x240 frame buffer, which the VGA pixel generator then scans out. On a `start` pulse it walks the sprite row by row at one pixel per clock. It skips key-colour pixels so they stay transparent, and it clips pixels that fall off the buffer edge. This makes it the write side of the frame-buffer and sprite-memory path that the display logic reads.

## Interface
- `VBUF_W`, default 320: frame-buffer width in pixels.
- `VBUF_H`, default 240: frame-buffer height in pixels.
- `KEY_COLOR`, default 12'h0F0: transparent colour. A pixel with this value is never written.
- `clk`, input, 1: system clock. One clock only.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a blit. Sampled only in IDLE.
- `src_base`, input, 16: sprite ROM address of pixel (0,0).
- `spr_w`, input, 7: sprite width, 0..127.
- `spr_h`, input, 7: sprite height, 0..127.
- `dst_x`, input, 9: destination column of the sprite's top-left pixel.
- `dst_y`, input, 8: destination row of the sprite's top-left pixel.
- `mirror`, input, 1: horizontal flip. Only effective when BLIT_MIRROR_EN is defined.
- `src_addr`, output, 16: sprite ROM read address.
- `src_data`, input, 12: ROM read data. The ROM is synchronous with 1-cycle latency.
- `fb_addr`, output, 18: frame-buffer write address.
- `fb_data`, output, 12: frame-buffer write data. Equal to `src_data`.
- `fb_we`, output, 1: frame-buffer write enable.
- `busy`, output, 1: high in RUN and DRAIN.
- `done`, output, 1: one-cycle completion pulse.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- **IDLE, `start`=1:** capture all parameter inputs into registers.
  - If `spr_w`=0 or `spr_h`=0, go to DONE.
  - Otherwise go to RUN with `col`=0 and `row`=0.
- **RUN:** each cycle, drive `src_addr = src_base + row*spr_w + scol`.
  - `scol` = `col`, or `spr_w-1-col` when mirroring is in effect.
  - Sum is modulo 2^16.
  - `col` increments each cycle. At `spr_w-1` it wraps to 0 and `row` increments.
  - After the address for (`spr_h-1`, `spr_w-1`) has been issued, go to DRAIN.
- **DRAIN:** one cycle, during which the last write completes. Then go to DONE.
- **DONE:** assert `done` for one cycle, then return to IDLE.
- **Write pipeline:** the destination coordinates and a valid bit are registered alongside each issued address.
  - The cycle after the address is issued: `fb_addr = (dst_y+row)*VBUF_W + (dst_x+col)`.
  - In that same cycle: `fb_we = valid & ~clip & (src_data != KEY_COLOR)`.
  - `clip` = `(dst_x+col >= VBUF_W) | (dst_y+row >= VBUF_H)`, computed at 10-bit/9-bit width so there is no wrap.
  - Clipped pixels are still traversed, so they still consume cycles.
- `start` is ignored outside IDLE. Parameter inputs may change freely once captured.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `done`=0, `fb_we`=0
  - `src_addr`=0, `fb_addr`=0
  - `col`, `row` and the valid bit all 0
- An asynchronous reset mid-blit aborts immediately. `fb_we` drops with reset and no `done` is issued.
- Start is accepted at edge E.
  - RUN spans cycles E+1 .. E+W*H.
  - Writes occur in cycles E+2 .. E+W*H+1; the last one is in DRAIN.
  - `done` is high in cycle E+W*H+2.
- Throughput is one pixel per clock. There are no stalls.
- Zero-size request: `done` is high in cycle E+1, `busy` never rises, and nothing is written.
- A new `start` can be accepted in the cycle after DONE, at the earliest.

## Configuration
- `BLIT_MIRROR_EN` defined: `mirror`=1 reads source columns in reverse (`scol = spr_w-1-col`). Destination order is unchanged.
- `BLIT_MIRROR_EN` undefined: the `mirror` input is ignored, `scol = col`, and the subtractor is not built.

## Test plan
- **Basic 4x2 blit:** `src_base`=0x100, `dst`=(10,20), no key pixels.
  - `src_addr` is 0x100..0x107 in consecutive cycles.
  - `fb_addr` is 6410..6413 then 6730..6733, each with `fb_we`=1.
  - `done` pulses exactly 10 cycles after the accept edge.
- **Transparency:** in the 4x2 sprite, pixel (0,2) is 12'h0F0.
  - That slot shows `fb_we`=0. The other 7 pixels are written.
  - Cycle count is unchanged.
- **Clipping:** 64x32 sprite at `dst`=(300,230).
  - Only columns 0..19 of rows 0..9 are written, 200 writes in total.
  - `done` is asserted at E+2050.
- **Mirror (macro defined):** 4x1 sprite with `mirror`=1.
  - `src_addr` sequence is base+3, +2, +1, +0.
  - Same stimulus with the macro undefined gives base+0..+3.
- **Boundaries:**
  - `spr_w`=0: `done` at E+1, no `fb_we`.
  - `start` held high through a blit: exactly one blit per IDLE visit.
  - `reset_n` low mid-RUN: `fb_we`, `busy` and `done` go to 0 immediately, and the block is in IDLE after release.
